// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_port_arbiter
//  Description : Two-requester arbiter for a single-port synchronous data
//                memory. Requester A (pipeline MEM stage) normally has
//                priority. Requester B (debug/loader) wins once it has been
//                denied STARVE_LIMIT consecutive cycles. Read data returns
//                one cycle after the grant and is steered to the requester
//                that issued the read.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                a_req/a_we/a_addr/a_wdata -> a_gnt/a_rvalid/a_rdata
//                                      - pipeline request / response
//                b_req/b_we/b_addr/b_wdata -> b_gnt/b_rvalid/b_rdata
//                                      - debug/loader request / response
//                mem_en/mem_we/mem_addr/mem_din, mem_dout
//                                      - data-memory port (1-cycle read)
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic       a_rvalid,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_gnt,
    output logic       b_rvalid,
    output logic [7:0] b_rdata,
    output logic       mem_en,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    input  logic [7:0] mem_dout
);

    localparam logic [2:0] c_STARVE_LIMIT = STARVE_LIMIT[2:0];

    // Owner of the read that returns data in the current cycle.
    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_A    = 2'd1;
    localparam logic [1:0] c_OWN_B    = 2'd2;

    logic [2:0] r_starve_cnt;
    logic [2:0] w_starve_cnt_nxt;
    logic [1:0] r_owner;
    logic [1:0] w_owner_nxt;
    logic       w_a_win;
    logic       w_b_win;
    logic       w_a_rvalid;
    logic       w_b_rvalid;

    // Arbitration: reset masks every request.
    always_comb begin
        w_a_win = 1'b0;
        w_b_win = 1'b0;
        if (!reset) begin
            if (a_req && b_req) begin
                if (r_starve_cnt == c_STARVE_LIMIT) begin
                    w_b_win = 1'b1;
                end else begin
                    w_a_win = 1'b1;
                end
            end else if (a_req) begin
                w_a_win = 1'b1;
            end else if (b_req) begin
                w_b_win = 1'b1;
            end
        end
    end

    // Memory port follows the winner; idle bus is driven to zero.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = 8'h00;
        mem_din  = 8'h00;
        if (w_a_win) begin
            mem_en   = 1'b1;
            mem_we   = a_we;
            mem_addr = a_addr;
            mem_din  = a_wdata;
        end else if (w_b_win) begin
            mem_en   = 1'b1;
            mem_we   = b_we;
            mem_addr = b_addr;
            mem_din  = b_wdata;
        end
    end

    // Starvation counter saturates so B keeps winning ties until served.
    always_comb begin
        w_starve_cnt_nxt = 3'd0;
        if (b_req && !w_b_win) begin
            if (r_starve_cnt == c_STARVE_LIMIT) begin
                w_starve_cnt_nxt = r_starve_cnt;
            end else begin
                w_starve_cnt_nxt = r_starve_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        w_owner_nxt = c_OWN_NONE;
        if (w_a_win && !a_we) begin
            w_owner_nxt = c_OWN_A;
        end else if (w_b_win && !b_we) begin
            w_owner_nxt = c_OWN_B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 3'd0;
            r_owner      <= c_OWN_NONE;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_owner      <= w_owner_nxt;
        end
    end

    // Reset in the return cycle of a read suppresses its valid so no stale
    // data escapes while the owner register has not yet been cleared.
    assign w_a_rvalid = (r_owner == c_OWN_A) && !reset;
    assign w_b_rvalid = (r_owner == c_OWN_B) && !reset;

    assign a_gnt    = w_a_win;
    assign b_gnt    = w_b_win;
    assign a_rvalid = w_a_rvalid;
    assign b_rvalid = w_b_rvalid;
    assign a_rdata  = w_a_rvalid ? mem_dout : 8'h00;
    assign b_rdata  = w_b_rvalid ? mem_dout : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_port_arbiter
//  Description : Self-checking bench for dm_port_arbiter. Per-cycle vectors
//                give inputs and expected grant/memory-bus values; read
//                returns are predicted into a queue when a read grant is
//                expected and compared one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

    logic       clk;
    logic       reset;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_din, mem_dout;

    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic       rst;
        logic       ar, aw;
        logic [7:0] aa, ad;
        logic       br, bw;
        logic [7:0] ba, bd;
        logic       eag, ebg, emwe;
        logic [7:0] eaddr, edin;
        int         ecnt;      // -1: counter not checked
    } vec_t;

    typedef struct {
        logic       va, vb;
        logic [7:0] d;
    } resp_t;

    resp_t sb[$];
    vec_t  tbl[19];

    dm_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        mem_dout      <= mem[mem_addr];
        end
    end

    function automatic vec_t mk(
        input logic rst,
        input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
        input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd,
        input logic eag, input logic ebg, input logic emwe,
        input logic [7:0] eaddr, input logic [7:0] edin, input int ecnt);
        vec_t v;
        v.rst = rst; v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
        v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
        v.eag = eag; v.ebg = ebg; v.emwe = emwe;
        v.eaddr = eaddr; v.edin = edin; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle %0d %s: got %0h, expected %0h", cyc, name, act, exp);
        end
    endtask

    task automatic run_cycle(input vec_t v);
        resp_t e;
        resp_t p;
        @(posedge clk);
        #1;
        reset   = v.rst;
        a_req   = v.ar; a_we = v.aw; a_addr = v.aa; a_wdata = v.ad;
        b_req   = v.br; b_we = v.bw; b_addr = v.ba; b_wdata = v.bd;
        @(negedge clk);
        chk("a_gnt",    {31'd0, a_gnt},  {31'd0, v.eag});
        chk("b_gnt",    {31'd0, b_gnt},  {31'd0, v.ebg});
        chk("one_gnt",  {31'd0, a_gnt & b_gnt}, 32'd0);
        chk("mem_en",   {31'd0, mem_en}, {31'd0, v.eag | v.ebg});
        chk("mem_we",   {31'd0, mem_we}, {31'd0, v.emwe});
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, v.eaddr});
        chk("mem_din",  {24'd0, mem_din},  {24'd0, v.edin});
        if (v.ecnt >= 0)
            chk("starve_cnt", {29'd0, dut.r_starve_cnt}, v.ecnt);
        // Response expected this cycle from the previous cycle's grant.
        e = '{va: 1'b0, vb: 1'b0, d: 8'h00};
        if (sb.size() > 0) e = sb.pop_front();
        if (v.rst) e = '{va: 1'b0, vb: 1'b0, d: 8'h00};
        chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, e.va});
        chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, e.vb});
        chk("a_rdata",  {24'd0, a_rdata},  {24'd0, e.va ? e.d : 8'h00});
        chk("b_rdata",  {24'd0, b_rdata},  {24'd0, e.vb ? e.d : 8'h00});
        // Predict next cycle's response from the expected grant.
        p = '{va: 1'b0, vb: 1'b0, d: 8'h00};
        if (!v.rst && v.eag && !v.aw) p = '{va: 1'b1, vb: 1'b0, d: mem[v.aa]};
        else if (!v.rst && v.ebg && !v.bw) p = '{va: 1'b0, vb: 1'b1, d: mem[v.ba]};
        sb.push_back(p);
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h01] = 8'h11;
        mem[8'h02] = 8'h22;
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
        b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;

        //            rst ar aw  aa     ad    br bw  ba     bd    eag ebg we  eaddr  edin  cnt
        tbl[0]  = mk(1, 1,0,8'h10,8'h00, 1,0,8'h02,8'h00, 0,0,0,8'h00,8'h00,-1); // reset masks
        tbl[1]  = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0);
        tbl[2]  = mk(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'h00, 0); // A read A5
        tbl[3]  = mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0);
        tbl[4]  = mk(0, 0,0,8'h00,8'h00, 1,1,8'h20,8'h3C, 0,1,1,8'h20,8'h3C, 0); // B write
        tbl[5]  = mk(0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h77, 0,1,0,8'h20,8'h77, 0); // B read
        tbl[6]  = mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0);
        tbl[7]  = mk(0, 1,0,8'h01,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h01,8'h00,-1); // alternate
        tbl[8]  = mk(0, 0,0,8'h00,8'h00, 1,0,8'h02,8'h00, 0,1,0,8'h02,8'h00, 0);
        tbl[9]  = mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0);
        tbl[10] = mk(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'h00, 0); // read, then reset
        tbl[11] = mk(1, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00,-1);
        tbl[12] = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0);
        tbl[13] = mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0);
        tbl[14] = mk(0, 1,0,8'h10,8'h5A, 1,0,8'h02,8'h00, 1,0,0,8'h10,8'h5A, 0); // B denied
        tbl[15] = mk(0, 1,0,8'h10,8'h5A, 1,0,8'h02,8'h00, 1,0,0,8'h10,8'h5A, 1);
        tbl[16] = mk(0, 1,0,8'h10,8'h5A, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'h5A, 2); // B drops
        tbl[17] = mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0);
        tbl[18] = mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0);

        for (int i = 0; i < 19; i++) run_cycle(tbl[i]);

        // Both requesters held high: B wins every fifth cycle, counter
        // climbs 0..4 and clears after each B grant.
        for (int i = 0; i < 10; i++) begin
            logic bw;
            bw = (i % 5 == 4);
            run_cycle(mk(0, 1,0,8'h01,8'h0A, 1,0,8'h02,8'h0B,
                         !bw, bw, 0, bw ? 8'h02 : 8'h01, bw ? 8'h0B : 8'h0A, i % 5));
        end
        run_cycle(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_port_arbiter.md
DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive denied cycles after which requester B wins arbitration (legal 1..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_req  input  1  pipeline MEM-stage access request.
REQ-005 a_we  input  1  pipeline access type: 1 = write, 0 = read.
REQ-006 a_addr  input  8  pipeline byte address.
REQ-007 a_wdata  input  8  pipeline write data.
REQ-008 a_gnt  output  1  pipeline access accepted this cycle.
REQ-009 a_rvalid  output  1  pipeline read data valid.
REQ-010 a_rdata  output  8  pipeline read data.
REQ-011 b_req, b_we, b_addr[7:0], b_wdata[7:0]  input  debug/loader port request fields, same meanings as a_*.
REQ-012 b_gnt, b_rvalid, b_rdata[7:0]  output  debug/loader port responses, same meanings as a_*.
REQ-013 mem_en  output  1  data-memory enable.
REQ-014 mem_we  output  1  data-memory write enable.
REQ-015 mem_addr  output  8  data-memory address.
REQ-016 mem_din  output  8  data-memory write data.
REQ-017 mem_dout  input  8  data-memory read data, valid one cycle after an enabled read edge.

Function
REQ-018 At most one grant per cycle; a_gnt and b_gnt are never both 1.
REQ-019 Grants are combinational from the current-cycle requests and the registered starvation count.
REQ-020 Arbitration when both request: B wins if starve_cnt == STARVE_LIMIT; otherwise A wins.
REQ-021 Arbitration with a single requester: that requester wins.
REQ-022 Arbitration with no requester: no grant; mem_en = 0.
REQ-023 Memory port follows the winner in the same cycle: mem_en = 1 and mem_we/mem_addr/mem_din = winner's we/addr/wdata.
REQ-024 With no grant, mem_we = 0, mem_addr = 0, and mem_din = 0.
REQ-025 starve_cnt is a 3-bit register.
REQ-026 starve_cnt increments when b_req=1 and b_gnt=0, saturating at STARVE_LIMIT.
REQ-027 starve_cnt clears to 0 when b_gnt=1 or b_req=0.
REQ-028 Read-return tracking uses a registered owner state with values NONE, A, and B.
REQ-029 Owner transitions at each edge: to A if A granted a read, to B if B granted a read, otherwise to NONE; writes always give NONE.
REQ-030 a_rvalid = (owner == A), and b_rvalid = (owner == B); each is a single-cycle pulse per granted read.
REQ-031 Read latency is 1 cycle: grant in cycle N gives rvalid plus data in cycle N+1.
REQ-032 a_rdata = mem_dout when a_rvalid = 1, else 8'h00; b_rdata follows the same rule with b_rvalid.
REQ-033 Back-to-back reads from alternating requesters are supported without a bubble; each rvalid goes only to the requester that issued that read.
REQ-034 Write grant gives no rvalid; the write is committed at the granting edge.
REQ-035 A denied requester holds its request fields stable until granted; the block does not queue requests.
REQ-036 A requester dropping its request while denied is legal and produces no memory access.

Reset
REQ-037 While reset = 1, a_gnt = b_gnt = 0 and mem_en = mem_we = 0, overriding all requests.
REQ-038 At the reset edge: starve_cnt = 0, owner = NONE, a_rvalid = b_rvalid = 0, and a_rdata = b_rdata = 8'h00.
REQ-039 Reset asserted in the cycle after a read grant suppresses that read's rvalid; no stale data is delivered.
REQ-040 In the first cycle after reset deasserts, arbitration uses starve_cnt = 0, so A has priority.

Verification
REQ-041 Basic read: only a_req, read, a_addr=8'h10, memory preloaded 8'hA5 -> a_gnt=1 same cycle, mem_addr=8'h10; next cycle a_rvalid=1, a_rdata=8'hA5, b_rvalid=0.
REQ-042 Write then read: B writes 8'h3C to 8'h20 (a_req=0), then B reads 8'h20 -> b_gnt=1 both cycles, no rvalid after the write, b_rdata=8'h3C one cycle after the read grant.
REQ-043 Starvation: a_req and b_req held high continuously with STARVE_LIMIT=4 -> A is granted cycles 0-3, B in cycle 4, A in cycles 5-8, B in cycle 9; starve_cnt returns to 0 after each B grant.
REQ-044 Alternating reads: A reads 8'h01 in cycle N and B reads 8'h02 in cycle N+1 (data 8'h11, 8'h22) -> a_rvalid/8'h11 in cycle N+1, b_rvalid/8'h22 in cycle N+2, never both high.
REQ-045 Reset mid-read: A read granted in cycle N, reset=1 in cycle N+1 -> a_rvalid=0 in cycle N+1 and N+2, all grants 0 during reset, starve_cnt=0 afterwards.
REQ-046 Idle/drop: b_req high for 2 denied cycles then dropped -> starve_cnt reads 2 then 0; mem_en=0 whenever no requester.
